// File: rtl/rv_inst_decoder_pkg.sv
// ---------------------------------------------------------------------------
// rv_inst_decoder_pkg
// Shared definitions for the RV32I instruction decoder: instruction/register
// geometry, base opcodes, ALU operation codes, branch condition codes,
// writeback source encodings and the internal control bundle type.
// ---------------------------------------------------------------------------
package rv_inst_decoder_pkg;

   // Geometry
   localparam int unsigned INST_WIDTH   = 32;
   localparam int unsigned NUM_REGISTER = 32;
   localparam int unsigned REG_ADDR_W   = $clog2(NUM_REGISTER);
   localparam int unsigned OPCODE       = 7;

   // Base opcodes (inst[6:0])
   localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
   localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;

   // ALU operation codes
   localparam int unsigned ALU_OP_W = 6;
   localparam logic [ALU_OP_W-1:0] OP_ALU_ADD  = 6'd0;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SUB  = 6'd1;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SLL  = 6'd2;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SLT  = 6'd3;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SLTU = 6'd4;
   localparam logic [ALU_OP_W-1:0] OP_ALU_XOR  = 6'd5;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SRL  = 6'd6;
   localparam logic [ALU_OP_W-1:0] OP_ALU_SRA  = 6'd7;
   localparam logic [ALU_OP_W-1:0] OP_ALU_OR   = 6'd8;
   localparam logic [ALU_OP_W-1:0] OP_ALU_AND  = 6'd9;

   // Branch condition codes
   localparam logic [2:0] BRANCH_BEQ      = 3'b000;
   localparam logic [2:0] BRANCH_BNE      = 3'b001;
   localparam logic [2:0] BRANCH_JAL_JALR = 3'b010;
   localparam logic [2:0] BRANCH_BLT      = 3'b100;
   localparam logic [2:0] BRANCH_BGE      = 3'b101;
   localparam logic [2:0] BRANCH_BLTU     = 3'b110;
   localparam logic [2:0] BRANCH_BGEU     = 3'b111;

   // Writeback source select
   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_PC4  = 2'b01;
   localparam logic [1:0] RES_LOAD = 2'b10;

   // Per-opcode control bundle; use_rs1/use_rs2 gate the source addresses.
   typedef struct packed {
      logic       branch;
      logic [1:0] result_mux;
      logic [2:0] branch_op;
      logic       mem_write;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       reg_write;
      logic       use_rs1;
      logic       use_rs2;
      logic       use_alu_decode;
      logic       illegal;
   } ctrl_t;

   // funct3 to ALU op, before the funct7[5] SUB/SRA refinement.
   function automatic logic [ALU_OP_W-1:0] alu_op_from_funct3(input logic [2:0] funct3);
      logic [ALU_OP_W-1:0] op;
      case (funct3)
         3'b000:  op = OP_ALU_ADD;
         3'b001:  op = OP_ALU_SLL;
         3'b010:  op = OP_ALU_SLT;
         3'b011:  op = OP_ALU_SLTU;
         3'b100:  op = OP_ALU_XOR;
         3'b101:  op = OP_ALU_SRL;
         3'b110:  op = OP_ALU_OR;
         default: op = OP_ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_inst_decoder_alu_op.sv
// ---------------------------------------------------------------------------
// rv_inst_decoder_alu_op
// Maps funct3/funct7[5] of an OP or OP-IMM instruction to an ALU op code.
// Ports:
//   funct3     in  3  inst[14:12]
//   funct7_b5  in  1  inst[30]
//   reg_form   in  1  1 = register-register (OP), 0 = immediate (OP-IMM)
//   alu_op     out 6  decoded ALU operation
// ---------------------------------------------------------------------------
module rv_inst_decoder_alu_op
   import rv_inst_decoder_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic                funct7_b5,
   input  logic                reg_form,
   output logic [ALU_OP_W-1:0] alu_op
);

   always_comb begin
      alu_op = alu_op_from_funct3(funct3);
      // Shift-right type is encoded in inst[30] for both forms.
      if (funct3 == 3'b101 && funct7_b5) begin
         alu_op = OP_ALU_SRA;
      end
      // Immediates have no SUB: inst[30] is part of the immediate there.
      if (reg_form && funct3 == 3'b000 && funct7_b5) begin
         alu_op = OP_ALU_SUB;
      end
   end

endmodule

// File: rtl/rv_inst_decoder.sv
// ---------------------------------------------------------------------------
// rv_inst_decoder
// Combinational RV32I instruction decoder for the single-cycle CPU. Splits an
// instruction word into register addresses, opcode and datapath controls.
// The only state is a sticky flag recording that an unsupported opcode was
// decoded since the last reset.
// Ports:
//   i_clk            in   1  clock (sticky flag only)
//   i_rst_n          in   1  synchronous active-low reset (sticky flag only)
//   i_inst           in  32  instruction word
//   o_opcode         out  7  inst[6:0]
//   o_branch         out  1  control-flow instruction (JAL, JALR, BRANCH)
//   o_result_mux     out  2  writeback source: ALU / PC+4 / load data
//   o_branch_op      out  3  branch condition code
//   o_mem_write      out  1  data memory write enable
//   o_alu_src_a      out  1  ALU operand A: 0 = rs1, 1 = PC
//   o_alu_src_b      out  1  ALU operand B: 0 = rs2, 1 = immediate
//   o_reg_write      out  1  register file write enable
//   o_alu_op         out  6  ALU operation code
//   o_rs1_addr       out  5  source register 1
//   o_rs2_addr       out  5  source register 2
//   o_rd_addr        out  5  destination register
//   o_illegal        out  1  current opcode is unsupported
//   o_illegal_seen   out  1  registered sticky illegal flag
// ---------------------------------------------------------------------------
module rv_inst_decoder
   import rv_inst_decoder_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [INST_WIDTH-1:0] i_inst,
   output logic [OPCODE-1:0]     o_opcode,
   output logic                  o_branch,
   output logic [1:0]            o_result_mux,
   output logic [2:0]            o_branch_op,
   output logic                  o_mem_write,
   output logic                  o_alu_src_a,
   output logic                  o_alu_src_b,
   output logic                  o_reg_write,
   output logic [ALU_OP_W-1:0]   o_alu_op,
   output logic [REG_ADDR_W-1:0] o_rs1_addr,
   output logic [REG_ADDR_W-1:0] o_rs2_addr,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic                  o_illegal,
   output logic                  o_illegal_seen
);

   logic [OPCODE-1:0]   opcode;
   logic [2:0]          funct3;
   logic                funct7_b5;
   logic                reg_form;
   logic [ALU_OP_W-1:0] alu_decoded;
   ctrl_t               ctrl;
   logic                illegal_seen_q;
   logic                illegal_seen_d;

   assign opcode    = i_inst[6:0];
   assign funct3    = i_inst[14:12];
   assign funct7_b5 = i_inst[30];
   assign reg_form  = (opcode == OP_ALU);

   // Remaining funct7 bits carry no decode information in RV32I base.
   logic unused_inst;
   assign unused_inst = ^{i_inst[31], i_inst[29:25]};

   rv_inst_decoder_alu_op u_alu_op (
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .reg_form  (reg_form),
      .alu_op    (alu_decoded)
   );

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_LUI: begin
            // rs1 held at x0 so the ALU produces x0 + imm.
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_AUIPC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_JAL: begin
            ctrl.branch     = 1'b1;
            ctrl.result_mux = RES_PC4;
            ctrl.branch_op  = BRANCH_JAL_JALR;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         OP_JALR: begin
            ctrl.branch     = 1'b1;
            ctrl.result_mux = RES_PC4;
            ctrl.branch_op  = BRANCH_JAL_JALR;
            ctrl.alu_src_b  = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.use_rs1    = 1'b1;
         end
         OP_BRANCH: begin
            // ALU forms the target PC + imm; the branch unit compares rs1/rs2.
            ctrl.branch    = 1'b1;
            ctrl.branch_op = funct3;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.use_rs1   = 1'b1;
            ctrl.use_rs2   = 1'b1;
         end
         OP_LOAD: begin
            ctrl.result_mux = RES_LOAD;
            ctrl.alu_src_b  = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.use_rs1    = 1'b1;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.use_rs1   = 1'b1;
            ctrl.use_rs2   = 1'b1;
         end
         OP_ALUI: begin
            ctrl.alu_src_b      = 1'b1;
            ctrl.reg_write      = 1'b1;
            ctrl.use_rs1        = 1'b1;
            ctrl.use_alu_decode = 1'b1;
         end
         OP_ALU: begin
            ctrl.reg_write      = 1'b1;
            ctrl.use_rs1        = 1'b1;
            ctrl.use_rs2        = 1'b1;
            ctrl.use_alu_decode = 1'b1;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

   assign o_opcode     = opcode;
   assign o_branch     = ctrl.branch;
   assign o_result_mux = ctrl.result_mux;
   assign o_branch_op  = ctrl.branch_op;
   assign o_mem_write  = ctrl.mem_write;
   assign o_alu_src_a  = ctrl.alu_src_a;
   assign o_alu_src_b  = ctrl.alu_src_b;
   assign o_reg_write  = ctrl.reg_write;
   assign o_alu_op     = ctrl.use_alu_decode ? alu_decoded : OP_ALU_ADD;
   assign o_rs1_addr   = ctrl.use_rs1 ? i_inst[19:15] : '0;
   assign o_rs2_addr   = ctrl.use_rs2 ? i_inst[24:20] : '0;
   assign o_rd_addr    = ctrl.reg_write ? i_inst[11:7] : '0;
   assign o_illegal    = ctrl.illegal;

   // Sticky illegal flag; reset wins over a simultaneous illegal opcode.
   always_comb begin
      illegal_seen_d = illegal_seen_q;
      if (!i_rst_n) begin
         illegal_seen_d = 1'b0;
      end else if (ctrl.illegal) begin
         illegal_seen_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      illegal_seen_q <= illegal_seen_d;
   end

   assign o_illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_rv_inst_decoder.sv
module tb_rv_inst_decoder;

   typedef struct packed {
      logic [6:0] opcode;
      logic       branch;
      logic [1:0] result_mux;
      logic [2:0] branch_op;
      logic       mem_write;
      logic       src_a;
      logic       src_b;
      logic       reg_write;
      logic [5:0] alu_op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       illegal;
      logic       illegal_seen;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        exp;
   } sb_entry_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst;
   logic [6:0]  opcode;
   logic        branch;
   logic [1:0]  result_mux;
   logic [2:0]  branch_op;
   logic        mem_write;
   logic        alu_src_a;
   logic        alu_src_b;
   logic        reg_write;
   logic [5:0]  alu_op;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic        illegal;
   logic        illegal_seen;

   int compared   = 0;
   int mismatched = 0;
   sb_entry_t sb_q[$];

   rv_inst_decoder dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_inst         (inst),
      .o_opcode       (opcode),
      .o_branch       (branch),
      .o_result_mux   (result_mux),
      .o_branch_op    (branch_op),
      .o_mem_write    (mem_write),
      .o_alu_src_a    (alu_src_a),
      .o_alu_src_b    (alu_src_b),
      .o_reg_write    (reg_write),
      .o_alu_op       (alu_op),
      .o_rs1_addr     (rs1_addr),
      .o_rs2_addr     (rs2_addr),
      .o_rd_addr      (rd_addr),
      .o_illegal      (illegal),
      .o_illegal_seen (illegal_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: table lookup straight from the opcode/control listing.
   // Row bits: branch, result_mux[1:0], mem_write, src_a, src_b, reg_write,
   // rs1 used, rs2 used.
   function automatic exp_t ref_decode(input logic [31:0] w);
      logic [6:0] ops  [9];
      logic [8:0] rows [9];
      logic [5:0] f3_op[8];
      exp_t e;
      int   k;
      ops  = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
      rows = '{9'b0_00_0_0_1_1_0_0,   // LUI
               9'b0_00_0_1_1_1_0_0,   // AUIPC
               9'b1_01_0_1_1_1_0_0,   // JAL
               9'b1_01_0_0_1_1_1_0,   // JALR
               9'b1_00_0_1_1_0_1_1,   // BRANCH
               9'b0_10_0_0_1_1_1_0,   // LOAD
               9'b0_00_1_0_1_0_1_1,   // STORE
               9'b0_00_0_0_1_1_1_0,   // ALUI
               9'b0_00_0_0_0_1_1_1};  // ALU
      f3_op = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
      e = '0;
      e.opcode = w[6:0];
      k = -1;
      for (int i = 0; i < 9; i++) if (ops[i] == w[6:0]) k = i;
      if (k < 0) begin
         e.illegal = 1'b1;
         return e;
      end
      {e.branch, e.result_mux, e.mem_write, e.src_a, e.src_b, e.reg_write} = rows[k][8:2];
      e.rs1 = rows[k][1] ? w[19:15] : 5'd0;
      e.rs2 = rows[k][0] ? w[24:20] : 5'd0;
      e.rd  = e.reg_write ? w[11:7] : 5'd0;
      if (k == 2 || k == 3) e.branch_op = 3'b010;
      else if (k == 4) e.branch_op = w[14:12];
      if (k == 7 || k == 8) begin
         e.alu_op = f3_op[w[14:12]];
         if (w[14:12] == 3'b101 && w[30]) e.alu_op = 6'd7;
         if (k == 8 && w[14:12] == 3'b000 && w[30]) e.alu_op = 6'd1;
      end
      return e;
   endfunction

   // Monitor: compare whatever the stimulus queued, away from the active edge.
   initial begin
      sb_entry_t ent;
      exp_t act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            act = '{opcode, branch, result_mux, branch_op, mem_write, alu_src_a, alu_src_b,
                    reg_write, alu_op, rs1_addr, rs2_addr, rd_addr, illegal, illegal_seen};
            compared++;
            if (act !== ent.exp) begin
               mismatched++;
               $display("FAIL decode inst=%08h got=%h expected=%h (seen got=%b exp=%b)",
                        ent.inst, act, ent.exp, act.illegal_seen, ent.exp.illegal_seen);
            end
         end
      end
   end

   // Stimulus: directed vectors first, then random; each step queues its expectation.
   initial begin
      logic [31:0] dir_inst[16];
      logic        dir_rst [16];
      logic [6:0]  legal_ops[9];
      logic [31:0] prev_inst;
      logic        prev_rst;
      logic        model_seen;
      logic [31:0] word;
      logic [6:0]  op;
      logic [31:0] next_inst;
      logic        next_rst;
      exp_t        e;
      sb_entry_t   ent;
      int          sel;

      dir_inst = '{32'h0007B2B7, 32'h4D000BEF, 32'h4D000BE7, 32'h03924563,
                   32'h01713703, 32'h00E12BA3, 32'h00F0C1B3, 32'h40208033,
                   32'h02020113, 32'h0000000F, 32'h00000013, 32'h0007B2B7,
                   32'h0000000F, 32'h00000073, 32'h00000013, 32'h40525293};
      dir_rst  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

      rst_n = 1'b0;
      inst  = 32'h0000000F;  // illegal while in reset: flag must still clear
      prev_inst  = inst;
      prev_rst   = rst_n;
      model_seen = 1'b0;

      for (int n = 0; n < 416; n++) begin
         @(posedge clk);
         if (!prev_rst) model_seen = 1'b0;
         else if (ref_decode(prev_inst).illegal) model_seen = 1'b1;
         if (n < 16) begin
            next_inst = dir_inst[n];
            next_rst  = dir_rst[n];
         end else begin
            word = $urandom();
            sel  = $urandom_range(0, 11);
            if (sel < 9) op = legal_ops[sel];
            else if (sel == 9) op = 7'b0001111;
            else if (sel == 10) op = 7'b1110011;
            else op = word[6:0];
            next_inst = {word[31:7], op};
            next_rst  = ($urandom_range(0, 15) != 0);
         end
         #1;
         inst  = next_inst;
         rst_n = next_rst;
         e = ref_decode(next_inst);
         e.illegal_seen = model_seen;
         ent.inst = next_inst;
         ent.exp  = e;
         sb_q.push_back(ent);
         prev_inst = next_inst;
         prev_rst  = next_rst;
      end

      for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
      @(posedge clk);
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d expected=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
